// File: rtl/sound_mix_pkg.sv
// Shared definitions for the sound_mix_n mixer and its saturation helper.
//   mix_state_t : pass sequencer states (IDLE / MAC / DONE)
//   unity_gain  : gain code that represents x1.0 for a given gain width
//   acc_width   : accumulator width that cannot overflow for a full pass
package sound_mix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } mix_state_t;

  // Gain is an unsigned fixed-point value with GAIN_W-1 fraction bits.
  function automatic int unity_gain(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  // One product needs in_w + gain_w + 1 bits (signed x zero-extended gain);
  // summing `channels` of them adds $clog2(channels) bits of growth.
  function automatic int acc_width(input int in_w, input int gain_w,
                                   input int channels);
    return in_w + gain_w + $clog2(channels) + 1;
  endfunction

endpackage

// File: rtl/sound_mix_sat.sv
// Arithmetic right shift (floor) followed by signed saturation.
// Purely combinational; reusable wherever a wide signed sum must be
// narrowed to an output sample width.
//   acc    : signed value, ACC_W bits
//   result : signed value clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
module sound_mix_sat #(
  parameter int ACC_W = 27,
  parameter int OUT_W = 16,
  parameter int SHIFT = 7
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] result
);

  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    // >>> on a signed operand truncates toward minus infinity.
    shifted = $signed(acc) >>> SHIFT;
    if (shifted > MAX_V) begin
      result = MAX_V[OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      result = MIN_V[OUT_W-1:0];
    end else begin
      result = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/sound_mix_n.sv
// N-source signed audio mixer with per-channel gain and enable.
// One time-shared multiplier performs one multiply-accumulate per clock.
//   clk, rst_n  : clock, synchronous active-low reset
//   sample_stb  : starts a mix pass (accepted only in IDLE)
//   in_data     : packed signed samples, channel k at [k*IN_W +: IN_W]
//   ch_en       : per-channel enable
//   gain_we/gain_addr/gain_din : gain register write port
//   sound       : saturated mix result, held between passes
//   sound_stb   : one-cycle pulse when sound updates
//   busy        : high from the first MAC cycle through DONE
//   overrun     : one-cycle pulse when sample_stb is rejected
//
// Strobe semantics: there is no back-pressure. sample_stb is a single-cycle
// request that is consumed only when the sequencer is IDLE; in any other
// state it is dropped and reported on overrun. sound_stb is a single-cycle
// notification with no acknowledge; sound stays valid until the next one.
module sound_mix_n
  import sound_mix_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int IN_W     = 16,
  parameter int OUT_W    = 16,
  parameter int GAIN_W   = 8,
  localparam int ADDR_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_stb,
  input  logic [CHANNELS*IN_W-1:0] in_data,
  input  logic [CHANNELS-1:0]      ch_en,
  input  logic                     gain_we,
  input  logic [ADDR_W-1:0]        gain_addr,
  input  logic [GAIN_W-1:0]        gain_din,
  output logic [OUT_W-1:0]         sound,
  output logic                     sound_stb,
  output logic                     busy,
  output logic                     overrun
);

  localparam int ACC_W  = acc_width(IN_W, GAIN_W, CHANNELS);
  localparam int PROD_W = IN_W + GAIN_W + 1;
  localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(unity_gain(GAIN_W));
  localparam logic [ADDR_W:0]   CH_LIMIT = (ADDR_W+1)'(CHANNELS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CHANNELS - 1);

  // Programmable gains
  logic [GAIN_W-1:0] gain_q [CHANNELS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) gain_q[k] <= UNITY;
    end else if (gain_we && ({1'b0, gain_addr} < CH_LIMIT)) begin
      gain_q[gain_addr] <= gain_din;
    end
  end

  // Pass snapshot and sequencer
  mix_state_t               state;
  logic signed [IN_W-1:0]   in_s   [CHANNELS];
  logic [GAIN_W-1:0]        gain_s [CHANNELS];
  logic [CHANNELS-1:0]      en_s;
  logic [ADDR_W-1:0]        idx;
  logic signed [ACC_W-1:0]  acc;

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] term;
  logic [OUT_W-1:0]         sat_out;

  // The single shared multiplier. Gain is zero-extended so that the full
  // unsigned range (e.g. 255) multiplies as a positive value.
  always_comb begin
    prod = PROD_W'(in_s[idx]) * PROD_W'($signed({1'b0, gain_s[idx]}));
    term = en_s[idx] ? prod : '0;
  end

  sound_mix_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (GAIN_W - 1)
  ) u_sat (
    .acc    (acc),
    .result (sat_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      en_s      <= '0;
      sound     <= '0;
      sound_stb <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        in_s[k]   <= '0;
        gain_s[k] <= UNITY;
      end
    end else begin
      sound_stb <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_stb) begin
            // gain_q is read before any same-edge write lands, so a
            // coincident gain write only affects the following pass.
            for (int k = 0; k < CHANNELS; k++) begin
              in_s[k]   <= in_data[k*IN_W +: IN_W];
              gain_s[k] <= gain_q[k];
            end
            en_s  <= ch_en;
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          overrun <= sample_stb;
          acc     <= acc + ACC_W'(term);
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          overrun   <= sample_stb;
          sound     <= sat_out;
          sound_stb <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sound_mix_n.sv
module tb_sound_mix_n;

  localparam int CH = 3;

  logic          clk;
  logic          rst_n;
  logic          sample_stb;
  logic [47:0]   in_data;
  logic [2:0]    ch_en;
  logic          gain_we;
  logic [1:0]    gain_addr;
  logic [7:0]    gain_din;
  logic [15:0]   sound;
  logic          sound_stb;
  logic          busy;
  logic          overrun;

  sound_mix_n #(.CHANNELS(CH), .IN_W(16), .OUT_W(16), .GAIN_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_stb (sample_stb),
    .in_data    (in_data),
    .ch_en      (ch_en),
    .gain_we    (gain_we),
    .gain_addr  (gain_addr),
    .gain_din   (gain_din),
    .sound      (sound),
    .sound_stb  (sound_stb),
    .busy       (busy),
    .overrun    (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state
  int          tb_in [CH];
  logic [2:0]  tb_en;
  int          model_gain [CH];
  logic [15:0] exp_q [$];

  // Mix rule: sum of enabled in*gain, floor-divide by 128, clamp to 16 bits.
  function automatic logic [15:0] model_mix();
    longint s;
    s = 0;
    for (int k = 0; k < CH; k++)
      if (tb_en[k]) s += longint'(tb_in[k]) * longint'(model_gain[k]);
    s = s >>> 7;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < CH; k++) model_gain[k] = 128;
    exp_q.delete();
  endfunction

  // driver tasks (all start and end at #1 after a rising edge)
  task automatic set_inputs(input int a, input int b, input int c, input logic [2:0] en);
    logic [15:0] pa, pb, pc;
    tb_in[0] = a; tb_in[1] = b; tb_in[2] = c; tb_en = en;
    pa = a[15:0]; pb = b[15:0]; pc = c[15:0];
    in_data = {pc, pb, pa};
    ch_en = en;
  endtask

  task automatic write_gain(input int addr, input int val);
    logic [31:0] a32, v32;
    a32 = addr; v32 = val;
    gain_we = 1'b1; gain_addr = a32[1:0]; gain_din = v32[7:0];
    @(posedge clk); #1;
    gain_we = 1'b0;
    if (addr < CH) model_gain[addr] = val;
  endtask

  task automatic start_pass();
    sample_stb = 1'b1;
    exp_q.push_back(model_mix());
    @(posedge clk); #1;
    sample_stb = 1'b0;
  endtask

  // Wait for sound_stb; checks value against the scoreboard and latency
  // (elapsed = cycles already spent since the accepting edge).
  task automatic wait_result(input string name, input int elapsed, output int busy_n);
    int cyc;
    logic [15:0] e;
    cyc = elapsed;
    busy_n = busy ? 1 : 0;
    while (!sound_stb && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) busy_n++;
    end
    total++;
    if (!sound_stb) begin
      bad++;
      $display("FAIL %s timeout: no sound_stb after %0d cycles, required 4", name, cyc);
    end else begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      if (cyc != CH + 1) begin
        bad++;
        $display("FAIL %s latency: got %0d required %0d", name, cyc, CH + 1);
      end
      total++;
      if (sound !== e) begin
        bad++;
        $display("FAIL %s sound: got %0d required %0d", name, $signed(sound), $signed(e));
      end
    end
  endtask

  task automatic count_stb(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (sound_stb) cnt++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    total++; if (sound !== 16'd0) begin bad++; $display("FAIL reset_sound: got %0d required 0", sound); end
    total++; if (sound_stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b required 0", sound_stb); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b required 0", overrun); end
  endtask

  task automatic test_unity();
    int bn;
    set_inputs(1000, -2000, 500, 3'b111);
    total++;
    if (model_mix() !== 16'hFE0C) begin bad++; $display("FAIL unity_model: got %0d required -500", $signed(model_mix())); end
    start_pass();
    wait_result("unity", 0, bn);
    total++; if (bn != 4) begin bad++; $display("FAIL unity_busy_cycles: got %0d required 4", bn); end
    @(posedge clk); #1;
    total++; if (sound_stb !== 1'b0) begin bad++; $display("FAIL unity_stb_width: got %b required 0", sound_stb); end
    total++; if (sound !== 16'hFE0C) begin bad++; $display("FAIL unity_hold: got %0d required -500", $signed(sound)); end
  endtask

  task automatic test_gain_enable();
    int bn;
    write_gain(0, 255); write_gain(1, 0); write_gain(2, 64);
    set_inputs(100, 7000, -256, 3'b101);
    start_pass();
    wait_result("gain_enable", 0, bn);
    total++; if (sound !== 16'd71) begin bad++; $display("FAIL gain_enable_abs: got %0d required 71", $signed(sound)); end
  endtask

  task automatic test_saturation();
    int bn;
    for (int k = 0; k < CH; k++) write_gain(k, 255);
    set_inputs(32767, 32767, 32767, 3'b111);
    start_pass();
    wait_result("sat_pos", 0, bn);
    total++; if (sound !== 16'h7FFF) begin bad++; $display("FAIL sat_pos_abs: got %0d required 32767", $signed(sound)); end
    set_inputs(-32768, -32768, -32768, 3'b111);
    start_pass();
    wait_result("sat_neg", 0, bn);
    total++; if (sound !== 16'h8000) begin bad++; $display("FAIL sat_neg_abs: got %0d required -32768", $signed(sound)); end
  endtask

  task automatic test_rounding();
    int bn;
    write_gain(0, 1);
    set_inputs(-1, 1234, -999, 3'b001);
    start_pass();
    wait_result("round_neg", 0, bn);
    total++; if (sound !== 16'hFFFF) begin bad++; $display("FAIL round_neg_abs: got %0d required -1", $signed(sound)); end
    set_inputs(1, 1234, -999, 3'b001);
    start_pass();
    wait_result("round_pos", 0, bn);
    total++; if (sound !== 16'd0) begin bad++; $display("FAIL round_pos_abs: got %0d required 0", $signed(sound)); end
  endtask

  task automatic test_overrun_snapshot();
    int bn, cnt;
    for (int k = 0; k < CH; k++) write_gain(k, 128);
    set_inputs(3000, -1000, 2000, 3'b111);
    start_pass();                              // now at T#1
    // change inputs and a gain during the pass; write lands at T+1
    set_inputs(-7000, 5000, 9, 3'b010);
    gain_we = 1'b1; gain_addr = 2'd0; gain_din = 8'd33;
    @(posedge clk); #1;                        // T+1
    gain_we = 1'b0; model_gain[0] = 33;
    sample_stb = 1'b1;
    @(posedge clk); #1;                        // T+2
    sample_stb = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_pulse: got %b required 1", overrun); end
    @(posedge clk); #1;                        // T+3
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_width: got %b required 0", overrun); end
    wait_result("snapshot", 3, bn);
    count_stb(8, cnt);
    total++; if (cnt != 0) begin bad++; $display("FAIL overrun_single_stb: extra strobes %0d required 0", cnt); end
    // strobe arriving in DONE is also rejected
    set_inputs(400, 400, 400, 3'b111);
    start_pass();                              // T#1
    repeat (2) begin @(posedge clk); #1; end   // T+2
    @(posedge clk); #1;                        // T+3
    sample_stb = 1'b1;
    @(posedge clk); #1;                        // T+4 (DONE edge)
    sample_stb = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_done: got %b required 1", overrun); end
    wait_result("done_pass", 4, bn);
    count_stb(8, cnt);
    total++; if (cnt != 0) begin bad++; $display("FAIL overrun_done_stb: extra strobes %0d required 0", cnt); end
  endtask

  task automatic test_coincident_gain();
    int bn;
    set_inputs(1000, 1000, 1000, 3'b001);
    gain_we = 1'b1; gain_addr = 2'd0; gain_din = 8'd64;
    start_pass();                              // snapshot uses old gain 33
    gain_we = 1'b0;
    model_gain[0] = 64;
    wait_result("coincident_old", 0, bn);
    start_pass();
    wait_result("coincident_new", 0, bn);
    total++; if (sound !== 16'd500) begin bad++; $display("FAIL coincident_new_abs: got %0d required 500", $signed(sound)); end
  endtask

  task automatic test_reset_mid();
    int bn, cnt;
    write_gain(1, 10);
    set_inputs(1000, 2000, 3000, 3'b111);
    start_pass();                              // T#1
    @(posedge clk); #1;                        // T+1
    rst_n = 1'b0;
    @(posedge clk); #1;                        // T+2 sampled low
    rst_n = 1'b1;
    model_reset();
    count_stb(8, cnt);
    total++; if (cnt != 0) begin bad++; $display("FAIL reset_mid_stb: strobes %0d required 0", cnt); end
    total++; if (sound !== 16'd0) begin bad++; $display("FAIL reset_mid_sound: got %0d required 0", $signed(sound)); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid_busy: got %b required 0", busy); end
    write_gain(3, 5);                          // out of range: ignored
    start_pass();
    wait_result("reset_mid_unity", 0, bn);
    total++; if (sound !== 16'd6000) begin bad++; $display("FAIL reset_mid_unity_abs: got %0d required 6000", $signed(sound)); end
  endtask

  task automatic test_back_to_back();
    int bn;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        write_gain($urandom_range(0, 3), $urandom_range(0, 255));
      end
      set_inputs(int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768,
                 3'($urandom_range(0, 7)));
      start_pass();
      wait_result("random", 0, bn);
      total++;
      if (overrun !== 1'b0) begin bad++; $display("FAIL random_overrun: got %b required 0", overrun); end
    end
  endtask

  initial begin
    rst_n = 1'b0; sample_stb = 1'b0; in_data = '0; ch_en = '0;
    gain_we = 1'b0; gain_addr = '0; gain_din = '0;
    for (int k = 0; k < CH; k++) tb_in[k] = 0;
    tb_en = '0;
    model_reset();
    test_reset();
    test_unity();
    test_gain_enable();
    test_saturation();
    test_rounding();
    test_overrun_snapshot();
    test_coincident_gain();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sound_mix_n.md
# sound_mix_n

Parametrised N-source signed audio mixer that replaces the fixed three-chip sum-of-enabled-sources in the OPLL slot path. Each source has a runtime-programmable gain and an enable bit. A single multiplier is time-shared across channels, one multiply-accumulate per clock. The result is saturated to the output width and presented with a one-cycle strobe. It sits between the FM/PSG cores and the audio output path.

## Interface
Parameters:
- CHANNELS, 3, number of sources (1..16)
- IN_W, 16, signed sample width per source
- OUT_W, 16, signed output width
- GAIN_W, 8, unsigned gain width; unity = 2^(GAIN_W-1)

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- sample_stb  in  1  one-cycle pulse that starts a mix pass
- in_data  in  CHANNELS*IN_W  packed signed samples; channel k = bits [k*IN_W +: IN_W]
- ch_en  in  CHANNELS  per-channel enable; a disabled channel contributes 0
- gain_we  in  1  gain register write strobe
- gain_addr  in  max(1,$clog2(CHANNELS))  gain register index
- gain_din  in  GAIN_W  gain value
- sound  out  OUT_W  signed mixed sample, held until the next pass completes
- sound_stb  out  1  one-cycle pulse when sound is updated
- busy  out  1  high while a pass is in progress
- overrun  out  1  one-cycle pulse when sample_stb arrives while busy

## Operation
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - On sample_stb, snapshot in_data, ch_en and all gain registers.
  - Clear the accumulator, set channel index = 0, go to MAC.
- MAC, one channel per cycle:
  - acc += ch_en_s[idx] ? in_s[idx] * gain_s[idx] : 0
  - The product is signed IN_W × unsigned GAIN_W; gain is zero-extended.
  - After idx = CHANNELS-1, go to DONE.
- Accumulator width: IN_W + GAIN_W + $clog2(CHANNELS) + 1. It cannot overflow.
- DONE:
  - Apply an arithmetic right shift by GAIN_W-1, i.e. truncation toward −∞.
  - Saturate to [−2^(OUT_W-1), 2^(OUT_W-1)−1].
  - Register the result into sound, pulse sound_stb, return to IDLE.
- Gain registers:
  - Reset value is unity (128 for GAIN_W = 8).
  - A write takes effect on the clock edge of gain_we.
  - A write with gain_addr ≥ CHANNELS is ignored.
- A pass uses only its snapshot. Changes to in_data, ch_en or gains during a pass affect only the next pass.
- sample_stb while busy, or in DONE:
  - The strobe is ignored and overrun pulses for one cycle.
  - The current pass is unaffected.

## Timing
- sample_stb sampled high at edge T:
  - Snapshot is taken at T.
  - MAC cycles occupy T+1 .. T+CHANNELS.
  - sound and sound_stb update at T+CHANNELS+1.
  - Latency is CHANNELS+1 clocks.
- busy is high from T+1 through the DONE cycle inclusive. Minimum strobe spacing is CHANNELS+2 clocks.
- Simultaneous gain_we and sample_stb in IDLE: the snapshot takes the old gain. The new gain applies from the next pass.
- Reset values:
  - sound = 0, sound_stb = 0, busy = 0, overrun = 0.
  - FSM = IDLE, accumulator = 0, all gains = unity.
- Reset asserted mid-pass: the pass is aborted, no sound_stb is issued, and gains return to unity.

## Structure
- Package sound_mix_pkg holds:
  - the FSM state enum (IDLE/MAC/DONE)
  - a function returning the unity gain for a given GAIN_W
  - a localparam function for the accumulator width
- Sub-module sound_mix_sat is purely combinational. It performs shift plus saturation from the accumulator width to OUT_W, parametrised by both widths, and is reused later for the output DAC path.
- The multiplier is inferred as a single instance, registered on the accumulator side only.

## Test plan
- Unity pass: after reset, CHANNELS = 3, in = {1000, −2000, 500}, all enabled, one strobe -> sound_stb at T+4, sound = −500, busy high exactly 4 cycles.
- Gain and enable: gains {255, 0, 64}, in = {100, 7000, −256}, ch_en = 3'b101 -> sound = (25500 − 16384) >>> 7 = 71.
- Saturation: in = {32767, 32767, 32767}, gains 255 -> sound = 32767. Negated inputs (−32768 each) -> sound = −32768.
- Rounding: single channel, in = −1, gain 1 -> sound = −1, not 0; in = 1, gain 1 -> sound = 0.
- Overrun and snapshot:
  - Strobe at T and again at T+2 -> overrun pulses at T+2, exactly one sound_stb.
  - Changing in_data and gains at T+1 leaves the result equal to the T-snapshot value.
  - gain_we coincident with the strobe applies only to the next pass.
- Reset mid-pass: rst_n low at T+2 -> no sound_stb, sound = 0. The next pass uses unity gains. A write to gain_addr = 3 (CHANNELS = 3) changes nothing.
